// File: rtl/nonrestoring_divider_if.sv
// ---------------------------------------------------------------------------
// nonrestoring_divider_if
//   Handshake and data bundle for the sequential signed divider.
//
//   start        requester -> divider  launch a division (sampled in IDLE/DONE)
//   data_in      requester -> divider  operand bus: dividend, then divisor
//   busy         divider -> requester  division in progress
//   done         divider -> requester  result valid (level)
//   quotient     divider -> requester  signed quotient, truncated toward zero
//   remainder    divider -> requester  signed remainder, sign of the dividend
//   div_by_zero  divider -> requester  divisor was zero
//
//   master: the requester side.  slave: the divider side.
// ---------------------------------------------------------------------------
interface nonrestoring_divider_if #(
    parameter int WIDTH = 32
);
    logic                    start;
    logic signed [WIDTH-1:0] data_in;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] quotient;
    logic signed [WIDTH-1:0] remainder;
    logic                    div_by_zero;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/nonrestoring_divider.sv
// ---------------------------------------------------------------------------
// nonrestoring_divider
//   Sequential signed integer divider, one quotient bit per clock, using the
//   non-restoring algorithm on operand magnitudes. Operands arrive serially
//   on data_in: dividend on the cycle after start is accepted, divisor on the
//   cycle after that. Quotient truncates toward zero; the remainder carries
//   the dividend's sign.
//
//   Ports
//     clk      system clock, rising edge
//     rst_n    asynchronous active-low reset; aborts any division in flight
//     bus      nonrestoring_divider_if.slave (start, data_in, busy, done,
//              quotient, remainder, div_by_zero)
//
//   Configuration macro
//     DIV_ZERO_CHECK_EN  when defined, a zero divisor skips the iteration and
//                        produces quotient=all ones, remainder=dividend,
//                        div_by_zero=1 with done three edges after start.
//                        When undefined, div_by_zero is tied low and a zero
//                        divisor runs the full iteration (result unspecified).
//
//   Latency: done rises WIDTH+3 edges after the edge that accepts start.
// ---------------------------------------------------------------------------
module nonrestoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    nonrestoring_divider_if.slave       bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_DVD,
        S_LOAD_DVR,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nx;

    // Iteration state. p is one bit wider than the operands so that the
    // shifted partial remainder (up to twice |divisor|) never overflows.
    logic [CW-1:0]           count;
    logic signed [WIDTH:0]   p;
    logic [WIDTH-1:0]        q;
    logic [WIDTH-1:0]        dvr_mag;
    logic                    dvd_sign;
    logic                    dvr_sign;

    logic signed [WIDTH-1:0] quotient_r;
    logic signed [WIDTH-1:0] remainder_r;

`ifdef DIV_ZERO_CHECK_EN
    logic [WIDTH-1:0]        dvd_raw;
    logic                    dvr_zero;
    logic                    dbz_r;
`endif

    // ---------------------------------------------------------------------
    // Combinational datapath
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0]        in_mag;
    logic signed [WIDTH:0]   dvr_ext;
    logic signed [WIDTH:0]   p_shift;
    logic signed [WIDTH:0]   p_step;
    logic signed [WIDTH:0]   p_fix;
    logic [WIDTH-1:0]        rem_mag;
    logic [WIDTH-1:0]        q_out;
    logic [WIDTH-1:0]        rem_out;

    // Magnitude as an unsigned WIDTH-bit value: |MIN_INT| = 2^(WIDTH-1) is
    // representable, so the most negative operand needs no special case.
    assign in_mag  = bus.data_in[WIDTH-1] ? (~bus.data_in + WIDTH'(1)) : bus.data_in;
    assign dvr_ext = {1'b0, dvr_mag};

    // Shift {P,Q} left by one, then subtract or add the divisor depending on
    // the sign the partial remainder had before the shift.
    assign p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
    assign p_step  = p[WIDTH] ? (p_shift + dvr_ext) : (p_shift - dvr_ext);

    // Final correction: a negative partial remainder is restored once.
    assign p_fix   = p[WIDTH] ? (p + dvr_ext) : p;
    assign rem_mag = p_fix[WIDTH-1:0];

    // Sign application. Negating 2^(WIDTH-1) wraps back onto itself, which
    // gives the MIN_INT / -1 -> MIN_INT wrap for free.
    assign q_out   = (dvd_sign ^ dvr_sign) ? (~q + WIDTH'(1)) : q;
    assign rem_out = dvd_sign ? (~rem_mag + WIDTH'(1)) : rem_mag;

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop in
    // the design samples values from before the edge, independent of the
    // order in which always blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state logic
    // ---------------------------------------------------------------------
    // NOTE: state_nx receives a default before the case statement, so every
    // path assigns it and no latch is inferred.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE,
            S_DONE: begin
                if (bus.start) begin
                    state_nx = S_LOAD_DVD;
                end
            end
            S_LOAD_DVD: begin
                state_nx = S_LOAD_DVR;
            end
            S_LOAD_DVR: begin
`ifdef DIV_ZERO_CHECK_EN
                // A zero divisor bypasses the iteration; FIX then writes the
                // fixed div-by-zero result one edge later.
                if (bus.data_in == '0) begin
                    state_nx = S_FIX;
                end else begin
                    state_nx = S_ITER;
                end
`else
                state_nx = S_ITER;
`endif
            end
            S_ITER: begin
                if (count == CW'(1)) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: begin
                state_nx = S_DONE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            p           <= '0;
            q           <= '0;
            dvr_mag     <= '0;
            dvd_sign    <= 1'b0;
            dvr_sign    <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
`ifdef DIV_ZERO_CHECK_EN
            dvd_raw     <= '0;
            dvr_zero    <= 1'b0;
            dbz_r       <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE,
                S_DONE: begin
`ifdef DIV_ZERO_CHECK_EN
                    if (bus.start) begin
                        dbz_r <= 1'b0;
                    end
`endif
                end
                S_LOAD_DVD: begin
                    // Dividend magnitude seeds Q; its bits shift into P.
                    dvd_sign <= bus.data_in[WIDTH-1];
                    q        <= in_mag;
`ifdef DIV_ZERO_CHECK_EN
                    dvd_raw  <= bus.data_in;
`endif
                end
                S_LOAD_DVR: begin
                    dvr_sign <= bus.data_in[WIDTH-1];
                    dvr_mag  <= in_mag;
                    p        <= '0;
                    count    <= CW'(WIDTH);
`ifdef DIV_ZERO_CHECK_EN
                    dvr_zero <= (bus.data_in == '0);
`endif
                end
                S_ITER: begin
                    p     <= p_step;
                    q     <= {q[WIDTH-2:0], ~p_step[WIDTH]};
                    count <= count - CW'(1);
                end
                S_FIX: begin
`ifdef DIV_ZERO_CHECK_EN
                    if (dvr_zero) begin
                        quotient_r  <= '1;
                        remainder_r <= dvd_raw;
                        dbz_r       <= 1'b1;
                    end else begin
                        quotient_r  <= q_out;
                        remainder_r <= rem_out;
                    end
`else
                    quotient_r  <= q_out;
                    remainder_r <= rem_out;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: busy/done decode straight from the registered state.
    // ---------------------------------------------------------------------
    assign bus.busy      = (state == S_LOAD_DVD) || (state == S_LOAD_DVR) ||
                           (state == S_ITER)     || (state == S_FIX);
    assign bus.done      = (state == S_DONE);
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
`ifdef DIV_ZERO_CHECK_EN
    assign bus.div_by_zero = dbz_r;
`else
    assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_nonrestoring_divider.sv
// ---------------------------------------------------------------------------
// tb_nonrestoring_divider
//   Directed vectors with hand-computed results. The driver pushes each
//   expected result into a scoreboard queue; an independent monitor pops and
//   compares whenever done rises, including the start-to-done latency.
// ---------------------------------------------------------------------------
module tb_nonrestoring_divider;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nonrestoring_divider_if #(.WIDTH(W)) dif ();

    nonrestoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    typedef struct {
        string        name;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        bit           chk_vals;
        int           lat;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int start_edge = 0;
    int dones = 0;
    int pushed = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: compares on every rising edge of done.
    logic done_d = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            done_d <= 1'b0;
        end else begin
            if (dif.done && !done_d) begin
                dones++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_latency"}, edge_cnt - start_edge, e.lat);
                    check({e.name, "_busy"}, 32'(dif.busy), 32'd0);
                    check({e.name, "_dbz"}, 32'(dif.div_by_zero), 32'(e.dbz));
                    if (e.chk_vals) begin
                        check({e.name, "_quotient"}, dif.quotient, e.q);
                        check({e.name, "_remainder"}, dif.remainder, e.r);
                    end
                end
            end
            done_d <= dif.done;
        end
    end

    // One division. abort_at > 0 asserts reset at that edge instead of
    // waiting for a result; pulse adds ignored start pulses at edges 5/10.
    task automatic run(input string name, input logic [W-1:0] dvd, input logic [W-1:0] dvr,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                       input bit chk_vals, input int lat, input bit pulse, input int abort_at);
        exp_t x;
        int   n;
        int   k;
        if (abort_at == 0) begin
            x.name = name; x.q = eq; x.r = er; x.dbz = edbz;
            x.chk_vals = chk_vals; x.lat = lat;
            sb.push_back(x);
            pushed++;
        end
        @(negedge clk);
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        start_edge = edge_cnt;
        dif.start = 1'b0;
        dif.data_in = dvd;
        check({name, "_edge0_busy_done"}, 32'({dif.busy, dif.done}), 32'b10);
        @(posedge clk);
        #1 dif.data_in = dvr;
        @(posedge clk);
        #1 dif.data_in = $urandom;
        if (abort_at > 0) begin
            while (edge_cnt - start_edge < abort_at) begin
                @(posedge clk);
                #1;
            end
            rst_n = 1'b0;
            #1;
            check({name, "_rst_quotient"}, dif.quotient, 32'd0);
            check({name, "_rst_remainder"}, dif.remainder, 32'd0);
            check({name, "_rst_flags"}, 32'({dif.busy, dif.done, dif.div_by_zero}), 32'd0);
            repeat (3) @(negedge clk);
            check({name, "_rst_hold_flags"}, 32'({dif.busy, dif.done}), 32'd0);
            rst_n = 1'b1;
            return;
        end
        n = 0;
        while (!dif.done && n < 100) begin
            @(negedge clk);
            k = edge_cnt - start_edge;
            dif.start = (pulse && (k == 4 || k == 9)) ? 1'b1 : 1'b0;
            n++;
        end
        dif.start = 1'b0;
        if (!dif.done) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        dif.start = 1'b0;
        dif.data_in = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_quotient", dif.quotient, 32'd0);
        check("reset_remainder", dif.remainder, 32'd0);
        check("reset_flags", 32'({dif.busy, dif.done, dif.div_by_zero}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("m100_d7",   -32'sd100, 32'sd7,   -32'sd14, -32'sd2, 1'b0, 1, W+3, 0, 0);
        run("p100_dm7",  32'sd100,  -32'sd7,  -32'sd14, 32'sd2,  1'b0, 1, W+3, 0, 0);
        run("p13_d20",   32'sd13,   32'sd20,  32'sd0,   32'sd13, 1'b0, 1, W+3, 0, 0);
        run("min_dm1",   MIN_INT,   -32'sd1,  MIN_INT,  32'sd0,  1'b0, 1, W+3, 0, 0);
        run("min_d1",    MIN_INT,   32'sd1,   MIN_INT,  32'sd0,  1'b0, 1, W+3, 0, 0);
        run("m7_dm2",    -32'sd7,   -32'sd2,  32'sd3,   -32'sd1, 1'b0, 1, W+3, 0, 0);
        run("p7_dm2",    32'sd7,    -32'sd2,  -32'sd3,  32'sd1,  1'b0, 1, W+3, 0, 0);
        run("max_dmin",  32'h7FFF_FFFF, MIN_INT, 32'sd0, 32'h7FFF_FFFF, 1'b0, 1, W+3, 0, 0);
        run("min_dmin",  MIN_INT,   MIN_INT,  32'sd1,   32'sd0,  1'b0, 1, W+3, 0, 0);
`ifdef DIV_ZERO_CHECK_EN
        run("p55_d0",    32'sd55,   32'sd0,   32'hFFFF_FFFF, 32'sd55, 1'b1, 1, 3, 0, 0);
`else
        run("p55_d0",    32'sd55,   32'sd0,   32'sd0,   32'sd0,  1'b0, 0, W+3, 0, 0);
`endif
        run("pulse_1000_dm33", 32'sd1000, -32'sd33, -32'sd30, 32'sd10, 1'b0, 1, W+3, 1, 0);
        // Back-to-back: start again while the previous result is in DONE.
        run("b2b_m45_d6", -32'sd45, 32'sd6,   -32'sd7,  -32'sd3, 1'b0, 1, W+3, 0, 0);
        run("abort_500_d3", 32'sd500, 32'sd3, 32'sd0,   32'sd0,  1'b0, 0, 0,   0, 12);
        @(negedge clk);
        run("p81_d9",    32'sd81,   32'sd9,   32'sd9,   32'sd0,  1'b0, 1, W+3, 0, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("done_count", dones, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
